// File: rtl/fft_bitrev_loader.sv
// Input-reorder controller for a 64-point FFT: fills a single-port RAM in natural order,
// then drains the frame in bit-reversed order. Output is 1 cycle behind the read address; no downstream backpressure.
module fft_bitrev_loader #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6,
    parameter int BITREV = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [WIDTH-1:0]  In_Data,
    output logic              Out_Valid,
    output logic [WIDTH-1:0]  Out_Data,
    output logic [ADDR_W-1:0] Out_Index,
    output logic              Out_Last,
    output logic              Ram_En,
    output logic              Ram_We,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic [WIDTH-1:0]  Ram_DI,
    input  logic [WIDTH-1:0]  Ram_DO
);

    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_rev;

    always_comb begin
        rd_rev = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            rd_rev[i] = rd_cnt[ADDR_W-1-i];
        end
    end

    assign In_Ready = (state == FILL);
    assign Ram_En   = (state == FILL) ? In_Valid : 1'b1;
    assign Ram_We   = (state == FILL) && In_Valid;
    assign Ram_DI   = In_Data;
    assign Ram_Addr = (state == FILL) ? wr_cnt : ((BITREV != 0) ? rd_rev : rd_cnt);
    assign Out_Data = Ram_DO;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            Out_Valid <= 1'b0;
            Out_Index <= '0;
            Out_Last  <= 1'b0;
        end else begin
            // Output registers track the read issued this cycle, matching the RAM's read latency.
            Out_Valid <= (state == DRAIN);
            Out_Index <= rd_cnt;
            Out_Last  <= (state == DRAIN) && (rd_cnt == LAST);
            case (state)
                FILL: begin
                    if (In_Valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Randomized frame-level bench: two instances (bit-reversed and natural drain) against a frame scoreboard.
module tb_fft_bitrev_loader;

    localparam int W = 32;
    localparam int A = 6;
    localparam int N = 64;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         In_Valid = 1'b0;
    logic [W-1:0] In_Data = '0;

    logic         r_rdy, r_ov, r_last, r_en, r_we;
    logic [W-1:0] r_od, r_di, r_do;
    logic [A-1:0] r_idx, r_addr;
    logic         n_rdy, n_ov, n_last, n_en, n_we;
    logic [W-1:0] n_od, n_di, n_do;
    logic [A-1:0] n_idx, n_addr;

    logic [W-1:0] r_mem [N];
    logic [W-1:0] n_mem [N];

    always #5 Clk = ~Clk;

    fft_bitrev_loader #(.WIDTH(W), .ADDR_W(A), .BITREV(1)) u_rev (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(r_rdy), .In_Data(In_Data),
        .Out_Valid(r_ov), .Out_Data(r_od), .Out_Index(r_idx), .Out_Last(r_last),
        .Ram_En(r_en), .Ram_We(r_we), .Ram_Addr(r_addr), .Ram_DI(r_di), .Ram_DO(r_do));

    fft_bitrev_loader #(.WIDTH(W), .ADDR_W(A), .BITREV(0)) u_nat (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(n_rdy), .In_Data(In_Data),
        .Out_Valid(n_ov), .Out_Data(n_od), .Out_Index(n_idx), .Out_Last(n_last),
        .Ram_En(n_en), .Ram_We(n_we), .Ram_Addr(n_addr), .Ram_DI(n_di), .Ram_DO(n_do));

    // Single-port RAMs with registered read data.
    always_ff @(posedge Clk) begin
        if (r_en) begin
            if (r_we) r_mem[r_addr] <= r_di;
            r_do <= r_mem[r_addr];
        end
        if (n_en) begin
            if (n_we) n_mem[n_addr] <= n_di;
            n_do <= n_mem[n_addr];
        end
    end

    // Frame-level model state.
    logic [W-1:0] frame     [N];
    logic [W-1:0] exp_frame [N];
    int acc        = 0;
    int drain_left = 0;
    int out_k      = -1;
    bit armed      = 0;
    int n_chk      = 0;
    int n_pass     = 0;

    function automatic int bitrev6(input int k);
        int r = 0;
        for (int i = 0; i < A; i++) r += ((k >> i) & 1) << (A - 1 - i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_cycle(input logic v);
        logic         rdy;
        logic [A-1:0] k;
        rdy = (drain_left == 0);
        k   = A'(N - drain_left);
        chk("r_in_ready", W'(r_rdy), W'(rdy));
        chk("n_in_ready", W'(n_rdy), W'(rdy));
        chk("r_ram_we",   W'(r_we),  W'(rdy && v));
        chk("n_ram_we",   W'(n_we),  W'(rdy && v));
        chk("r_ram_en",   W'(r_en),  W'(rdy ? v : 1'b1));
        chk("n_ram_en",   W'(n_en),  W'(rdy ? v : 1'b1));
        if (rdy && v) begin
            chk("r_wr_addr", W'(r_addr), W'(acc));
            chk("n_wr_addr", W'(n_addr), W'(acc));
        end else if (!rdy) begin
            chk("r_rd_addr", W'(r_addr), W'(bitrev6(int'(k))));
            chk("n_rd_addr", W'(n_addr), W'(k));
        end
        chk("r_out_valid", W'(r_ov),   W'(out_k >= 0));
        chk("n_out_valid", W'(n_ov),   W'(out_k >= 0));
        chk("r_out_last",  W'(r_last), W'(out_k == N - 1));
        chk("n_out_last",  W'(n_last), W'(out_k == N - 1));
        chk("r_out_index", W'(r_idx),  W'((out_k >= 0) ? out_k : 0));
        chk("n_out_index", W'(n_idx),  W'((out_k >= 0) ? out_k : 0));
        if (out_k >= 0) begin
            chk("r_out_data", r_od, exp_frame[bitrev6(out_k)]);
            chk("n_out_data", n_od, exp_frame[out_k]);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic accepted);
        int nk;
        @(negedge Clk);
        In_Valid = v;
        In_Data  = d;
        Rst      = r;
        #1;
        if (armed) check_cycle(v);
        @(posedge Clk);
        accepted = 1'b0;
        if (r) begin
            acc = 0; drain_left = 0; out_k = -1;
        end else begin
            nk = (drain_left > 0) ? (N - drain_left) : -1;
            if (drain_left > 0) begin
                drain_left--;
            end else if (v) begin
                accepted = 1'b1;
                frame[acc] = d;
                acc++;
                if (acc == N) begin
                    acc = 0;
                    drain_left = N;
                    for (int i = 0; i < N; i++) exp_frame[i] = frame[i];
                end
            end
            out_k = nk;
        end
    endtask

    task automatic reset_cycles(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b1, $urandom, 1'b1, a);
    endtask

    // mode 0: contiguous, 1: valid every other cycle, 2: random valid.
    // Valid is held high with a poison word whenever the block should be draining.
    task automatic fill(input logic [W-1:0] base, input int mode, input int n);
        int   got = 0;
        int   cyc = 0;
        logic v, a;
        while (got < n && cyc < 2000) begin
            if (drain_left > 0)  v = 1'b1;
            else if (mode == 1)  v = (cyc % 2 == 0);
            else if (mode == 2)  v = 1'($urandom_range(0, 1));
            else                 v = 1'b1;
            step(v, (drain_left > 0) ? 32'hDEADBEEF : base + W'(acc), 1'b0, a);
            if (a) got++;
            cyc++;
        end
        if (got < n) chk("fill_timeout", W'(got), W'(n));
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, a);
    endtask

    initial begin
        logic a;
        int   cyc;
        reset_cycles(2);
        armed = 1;
        reset_cycles(1);

        fill(32'd0, 0, N);
        idle(70);

        fill(32'd0, 1, N);
        idle(70);

        fill(32'd0, 0, N);
        fill(32'd100, 0, N);
        idle(70);

        fill(32'h1000, 2, 20);
        reset_cycles(1);
        fill(32'h1000, 0, N);
        idle(70);

        fill(32'h2000, 2, N);
        cyc = 0;
        while (out_k != 10 && cyc < 300) begin
            step(1'b0, $urandom, 1'b0, a);
            cyc++;
        end
        if (out_k != 10) chk("drain_timeout", W'(out_k), W'(10));
        reset_cycles(1);
        fill(32'h3000, 2, N);
        idle(70);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
